// File: rtl/combo_lock_seq.sv
// N-step hex combination lock: captures {A,B} pairs on enter edges, shows them on
// active-low 7-segment slots, unlocks on a full match and enforces a timed lockout.
module combo_lock_seq #(
  parameter int                     NUM_STEPS      = 3,
  parameter logic [8*NUM_STEPS-1:0] CODE           = 24'h281996,
  parameter int                     MAX_FAILS      = 3,
  parameter int                     LOCKOUT_CYCLES = 16,
  localparam int                    SW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int                    FW = $clog2(MAX_FAILS + 1),
  localparam int                    CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [3:0]               A,
  input  logic [3:0]               B,
  input  logic                     enter,
  input  logic                     clear,
  output logic [14*NUM_STEPS-1:0]  seg_n,
  output logic                     unlocked,
  output logic                     locked_out,
  output logic [SW-1:0]            step,
  output logic [FW-1:0]            fail_count
);

  typedef enum logic [1:0] {ST_ENTRY, ST_UNLOCKED, ST_LOCKOUT} state_e;

  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_STEPS - 1);

  state_e                  state_q, state_d;
  logic [SW-1:0]           step_q, step_d;
  logic [FW-1:0]           fail_q, fail_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    match_q, match_d;
  logic [14*NUM_STEPS-1:0] seg_q, seg_d;
  logic                    enter_q;
  logic                    enter_edge;
  logic                    match_now;

  // Active-high segment pattern (bit6..0 = g..a) for one hex digit.
  function automatic logic [6:0] hex7(input logic [3:0] d);
    case (d)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h67;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Step 0 occupies the most significant byte of CODE.
  function automatic logic [7:0] expected_pair(input logic [SW-1:0] k);
    logic [8*NUM_STEPS-1:0] shifted;
    shifted = CODE >> (8 * (NUM_STEPS - 1 - int'(k)));
    return shifted[7:0];
  endfunction

  assign enter_edge = enter & ~enter_q;
  assign match_now  = match_q & ({A, B} == expected_pair(step_q));

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d = state_q;
    step_d  = step_q;
    fail_d  = fail_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    seg_d   = seg_q;

    case (state_q)
      ST_ENTRY: begin
        if (clear) begin
          step_d  = '0;
          match_d = 1'b1;
          seg_d   = '1;
        end else if (enter_edge) begin
          seg_d[14*int'(step_q) +: 14] = ~{hex7(A), hex7(B)};
          if (step_q != LAST_STEP) begin
            step_d  = step_q + SW'(1);
            match_d = match_now;
          end else if (match_now) begin
            state_d = ST_UNLOCKED;
            fail_d  = '0;
            match_d = 1'b1;
          end else if (fail_q + FW'(1) < FW'(MAX_FAILS)) begin
            fail_d  = fail_q + FW'(1);
            step_d  = '0;
            match_d = 1'b1;
            seg_d   = '1;
          end else begin
            state_d = ST_LOCKOUT;
            fail_d  = FW'(MAX_FAILS);
            cnt_d   = CW'(LOCKOUT_CYCLES - 1);
            step_d  = '0;
            match_d = 1'b1;
            seg_d   = '1;
          end
        end
      end

      ST_UNLOCKED: begin
        if (clear) begin
          state_d = ST_ENTRY;
          step_d  = '0;
          match_d = 1'b1;
          seg_d   = '1;
        end
      end

      ST_LOCKOUT: begin
        if (cnt_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: state_d = ST_ENTRY;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_ENTRY;
      step_q  <= '0;
      fail_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b1;
      seg_q   <= '1;
      enter_q <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
      seg_q   <= seg_d;
      enter_q <= enter;
    end
  end

  assign seg_n      = seg_q;
  assign unlocked   = (state_q == ST_UNLOCKED);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign step       = step_q;
  assign fail_count = fail_q;

endmodule

// File: tb/tb_combo_lock_seq.sv
// Self-checking bench for combo_lock_seq: a pair-list model checked every cycle on a
// 3-step and a 4-step instance, plus directed literal expectations.
module tb_combo_lock_seq;

  localparam int MAXF = 3;
  localparam int LCYC = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic [1:0] rst_s, en_s, clr_s;
  logic [3:0] a_s [2];
  logic [3:0] b_s [2];

  logic [41:0] seg3;
  logic        unl3, lo3;
  logic [1:0]  step3, fc3;
  logic [55:0] seg4;
  logic        unl4, lo4;
  logic [1:0]  step4, fc4;

  combo_lock_seq dut3 (
    .clock(clock), .reset(rst_s[0]), .A(a_s[0]), .B(b_s[0]), .enter(en_s[0]), .clear(clr_s[0]),
    .seg_n(seg3), .unlocked(unl3), .locked_out(lo3), .step(step3), .fail_count(fc3)
  );

  combo_lock_seq #(.NUM_STEPS(4), .CODE(32'hA1B2C3D4)) dut4 (
    .clock(clock), .reset(rst_s[1]), .A(a_s[1]), .B(b_s[1]), .enter(en_s[1]), .clear(clr_s[1]),
    .seg_n(seg4), .unlocked(unl4), .locked_out(lo4), .step(step4), .fail_count(fc4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic int nsteps(input int i);
    return (i == 0) ? 3 : 4;
  endfunction

  function automatic logic [7:0] code_byte(input int i, input int k);
    logic [31:0] c;
    c = (i == 0) ? 32'h0028_1996 : 32'hA1B2_C3D4;
    return c[8*(nsteps(i)-1-k) +: 8];
  endfunction

  int         m_mode   [2];   // 0 entry, 1 unlocked, 2 lockout
  int         m_cnt    [2];   // pairs entered in this attempt
  int         m_fails  [2];
  int         m_remain [2];   // lockout cycles still to show
  bit         m_prev   [2];
  bit         m_valid  [2] = '{1'b0, 1'b0};
  logic [7:0] m_pairs  [2][4];

  task automatic model_tick(input int i);
    bit e;
    bit ok;
    if (rst_s[i]) begin
      m_mode[i] = 0; m_cnt[i] = 0; m_fails[i] = 0; m_prev[i] = 1'b1; m_valid[i] = 1'b1;
      return;
    end
    e = en_s[i] && !m_prev[i];
    m_prev[i] = en_s[i];
    case (m_mode[i])
      0: begin
        if (clr_s[i]) m_cnt[i] = 0;
        else if (e) begin
          m_pairs[i][m_cnt[i]] = {a_s[i], b_s[i]};
          m_cnt[i]++;
          if (m_cnt[i] == nsteps(i)) begin
            ok = 1'b1;
            for (int k = 0; k < nsteps(i); k++)
              if (m_pairs[i][k] != code_byte(i, k)) ok = 1'b0;
            if (ok) begin
              m_mode[i] = 1; m_fails[i] = 0;
            end else begin
              m_cnt[i] = 0;
              m_fails[i]++;
              if (m_fails[i] == MAXF) begin
                m_mode[i] = 2; m_remain[i] = LCYC;
              end
            end
          end
        end
      end
      1: if (clr_s[i]) begin m_mode[i] = 0; m_cnt[i] = 0; end
      default: begin
        m_remain[i]--;
        if (m_remain[i] == 0) begin m_mode[i] = 0; m_fails[i] = 0; end
      end
    endcase
  endtask

  task automatic compare(input int i, input logic [55:0] seg, input logic unl, input logic lo,
                         input logic [1:0] stp, input logic [1:0] fc);
    logic [55:0] es;
    int          n;
    n  = nsteps(i);
    es = '0;
    for (int k = 0; k < n; k++)
      es[14*k +: 14] = (k < m_cnt[i]) ? {~hex_tbl[m_pairs[i][k][7:4]], ~hex_tbl[m_pairs[i][k][3:0]]}
                                      : 14'h3FFF;
    check($sformatf("dut%0d_seg_n", i), 64'(seg), 64'(es));
    check($sformatf("dut%0d_unlocked", i), 64'(unl), 64'(m_mode[i] == 1));
    check($sformatf("dut%0d_locked_out", i), 64'(lo), 64'(m_mode[i] == 2));
    check($sformatf("dut%0d_step", i), 64'(stp), 64'((m_cnt[i] < n) ? m_cnt[i] : n - 1));
    check($sformatf("dut%0d_fail_count", i), 64'(fc), 64'(m_fails[i]));
  endtask

  always @(posedge clock) begin
    model_tick(0);
    model_tick(1);
  end

  always @(negedge clock) begin
    if (m_valid[0]) compare(0, {14'b0, seg3}, unl3, lo3, step3, fc3);
    if (m_valid[1]) compare(1, seg4, unl4, lo4, step4, fc4);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic press(input int i, input logic [3:0] a, input logic [3:0] b);
    a_s[i] = a; b_s[i] = b; en_s[i] = 1'b1;
    tick(1);
    en_s[i] = 1'b0;
    tick(1);
  endtask

  task automatic pulse_clear(input int i);
    clr_s[i] = 1'b1;
    tick(1);
    clr_s[i] = 1'b0;
    tick(1);
  endtask

  task automatic right_code3();
    press(0, 4'h2, 4'h8); press(0, 4'h1, 4'h9); press(0, 4'h9, 4'h6);
  endtask

  task automatic wrong_code3();
    press(0, 4'h3, 4'h3); press(0, 4'h1, 4'h9); press(0, 4'h9, 4'h6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_s = 2'b11; en_s = 2'b01; clr_s = 2'b00;
    a_s[0] = 4'h2; b_s[0] = 4'h8; a_s[1] = 4'h0; b_s[1] = 4'h0;
    tick(3);
    rst_s = 2'b00;
    tick(2);
    check("held_enter_through_reset_step", 64'(step3), 64'd0);
    en_s[0] = 1'b0;
    tick(1);
    check("reset_seg_blank", 64'(seg3), {22'b0, {42{1'b1}}});
    check("reset_unlocked", 64'(unl3), 64'd0);

    // correct entry
    right_code3();
    check("unlock_after_code", 64'(unl3), 64'd1);
    check("slot0_28", 64'(seg3[13:0]), 64'({7'h24, 7'h00}));
    check("slot1_19", 64'(seg3[27:14]), 64'({7'h79, 7'h18}));
    check("slot2_96", 64'(seg3[41:28]), 64'({7'h18, 7'h02}));
    check("unlock_fail_count", 64'(fc3), 64'd0);
    press(0, 4'h3, 4'h3);
    check("enter_ignored_unlocked", 64'(seg3[13:0]), 64'({7'h24, 7'h00}));
    pulse_clear(0);
    check("relock_unlocked", 64'(unl3), 64'd0);
    check("relock_step", 64'(step3), 64'd0);

    // repeated failures and lockout
    for (int r = 1; r <= 2; r++) begin
      wrong_code3();
      check("fail_count_after_wrong", 64'(fc3), 64'(r));
    end
    check("wrong_seg_blank", 64'(seg3), {22'b0, {42{1'b1}}});
    press(0, 4'h3, 4'h3); press(0, 4'h1, 4'h9);
    a_s[0] = 4'h9; b_s[0] = 4'h6; en_s[0] = 1'b1;
    tick(1);
    en_s[0] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!lo3) break;
      cnt++;
      a_s[0] = 4'h2; b_s[0] = 4'h8;
      en_s[0]  = (i % 3 == 1);
      clr_s[0] = (i == 7);
      tick(1);
    end
    en_s[0] = 1'b0; clr_s[0] = 1'b0;
    check("lockout_length", 64'(cnt), 64'(LCYC));
    check("lockout_exit_fail_count", 64'(fc3), 64'd0);
    check("lockout_no_capture_step", 64'(step3), 64'd0);

    // clear mid-attempt keeps fail_count
    wrong_code3();
    press(0, 4'h2, 4'h8);
    check("partial_step", 64'(step3), 64'd1);
    pulse_clear(0);
    check("clear_step", 64'(step3), 64'd0);
    check("clear_seg_blank", 64'(seg3), {22'b0, {42{1'b1}}});
    check("clear_keeps_fail_count", 64'(fc3), 64'd1);
    right_code3();
    check("unlock_after_clear", 64'(unl3), 64'd1);
    check("unlock_clears_fails", 64'(fc3), 64'd0);
    pulse_clear(0);

    // held enter captures once; clear beats a simultaneous edge
    a_s[0] = 4'h2; b_s[0] = 4'h8; en_s[0] = 1'b1;
    tick(10);
    check("held_enter_once", 64'(step3), 64'd1);
    en_s[0] = 1'b0;
    tick(1);
    pulse_clear(0);
    en_s[0] = 1'b1; clr_s[0] = 1'b1;
    tick(1);
    clr_s[0] = 1'b0;
    tick(2);
    en_s[0] = 1'b0;
    tick(1);
    check("clear_wins_step", 64'(step3), 64'd0);
    check("clear_wins_seg", 64'(seg3), {22'b0, {42{1'b1}}});

    // reset while unlocked, then mid-lockout
    right_code3();
    check("pre_reset_unlocked", 64'(unl3), 64'd1);
    rst_s[0] = 1'b1; tick(1); rst_s[0] = 1'b0;
    check("reset_from_unlocked", 64'(unl3), 64'd0);
    check("reset_from_unlocked_seg", 64'(seg3), {22'b0, {42{1'b1}}});
    tick(1);
    for (int r = 0; r < 3; r++) wrong_code3();
    tick(4);
    check("mid_lockout", 64'(lo3), 64'd1);
    rst_s[0] = 1'b1; tick(1); rst_s[0] = 1'b0;
    check("reset_from_lockout", 64'(lo3), 64'd0);
    check("reset_from_lockout_fails", 64'(fc3), 64'd0);
    check("reset_from_lockout_step", 64'(step3), 64'd0);
    tick(2);

    // four-step instance
    press(1, 4'hA, 4'h1); press(1, 4'hB, 4'h2); press(1, 4'hC, 4'h3); press(1, 4'hD, 4'h4);
    check("n4_unlock", 64'(unl4), 64'd1);
    check("n4_slot3", 64'(seg4[55:42]), 64'({7'h21, 7'h19}));
    pulse_clear(1);
    press(1, 4'hA, 4'h1); press(1, 4'hB, 4'h2); press(1, 4'hC, 4'h3); press(1, 4'hD, 4'h5);
    check("n4_wrong_last_fails", 64'(fc4), 64'd1);
    check("n4_wrong_last_blank", 64'(seg4), {8'b0, {56{1'b1}}});
    check("n4_wrong_last_locked", 64'(unl4), 64'd0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
